// File: rtl/seg7_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg7_ctrl_pkg
// Shared definitions for the seg7 mode controller:
//   - mode_e        : display mode encoding (COUNT / SPIN / BLINK)
//   - SEG_x         : one-hot segment constants, bit order {g,f,e,d,c,b,a}
//   - BLINK_ON/OFF  : full-on / full-off override patterns
//   - spin_pattern  : spin position (0..5) -> one-hot segment a..f
//   - seg_pattern   : mode + animation state -> seg_override value
// -----------------------------------------------------------------------------
package seg7_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SPIN  = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  // Segment bit positions inside {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_A = 7'h01;
  localparam logic [6:0] SEG_B = 7'h02;
  localparam logic [6:0] SEG_C = 7'h04;
  localparam logic [6:0] SEG_D = 7'h08;
  localparam logic [6:0] SEG_E = 7'h10;
  localparam logic [6:0] SEG_F = 7'h20;

  localparam logic [6:0] BLINK_ON  = 7'h7F;
  localparam logic [6:0] BLINK_OFF = 7'h00;

  // Last spin position; the next tick returns to position 0 (segment a).
  localparam logic [2:0] SPIN_LAST = 3'd5;

  function automatic logic [6:0] spin_pattern(input logic [2:0] pos);
    logic [6:0] pat;
    case (pos)
      3'd0:    pat = SEG_A;
      3'd1:    pat = SEG_B;
      3'd2:    pat = SEG_C;
      3'd3:    pat = SEG_D;
      3'd4:    pat = SEG_E;
      3'd5:    pat = SEG_F;
      default: pat = SEG_A;
    endcase
    return pat;
  endfunction

  // COUNT never drives the override, so its pattern is all-off.
  function automatic logic [6:0] seg_pattern(input mode_e      mode,
                                             input logic [2:0] pos,
                                             input logic       phase_on);
    logic [6:0] pat;
    case (mode)
      MODE_SPIN:  pat = spin_pattern(pos);
      MODE_BLINK: pat = phase_on ? BLINK_ON : BLINK_OFF;
      default:    pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_mode_ctrl_if
// Display-side bundle produced by seg7_mode_ctrl.
//   digit        [3:0] hex value for the downstream seg7 decoder
//   seg_override [6:0] direct segment pattern {g,f,e,d,c,b,a}
//   override_en        1 = show seg_override, 0 = show decoded digit
//   dp                 decimal point, 1 while paused
//   mode         [1:0] current mode (0 COUNT, 1 SPIN, 2 BLINK); this is the
//                      controller FSM state, visible for checkers
//   evt          [3:0] one-hot, one-cycle strobe of the accepted button event
//
// Handshake semantics: there is no valid/ready pair on this bundle. Every
// signal is a registered level that the consumer may sample on any clock,
// except evt, which is a single-cycle strobe with no back-pressure: a
// consumer that is not looking on that cycle misses the event.
// -----------------------------------------------------------------------------
interface seg7_mode_ctrl_if;

  logic [3:0] digit;
  logic [6:0] seg_override;
  logic       override_en;
  logic       dp;
  logic [1:0] mode;
  logic [3:0] evt;

  modport master (
    output digit,
    output seg_override,
    output override_en,
    output dp,
    output mode,
    output evt
  );

  modport slave (
    input digit,
    input seg_override,
    input override_en,
    input dp,
    input mode,
    input evt
  );

endinterface

// File: rtl/seg7_mode_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button conditioner: 2-flop synchronizer, stability counter and
// registered rising-edge detector.
//   clk, rst_n  system clock, synchronous active-low reset
//   ena         enable; low holds every register
//   btn_raw     raw asynchronous bouncing button level
//   press       one-cycle pulse after the debounced level goes 0 -> 1
//
// Timing: the first edge that samples a clean high is E1. The synchronizer
// output is first seen at E3, the stable level flips at E(N+2) after N
// disagreeing samples, and press is registered at E(N+3). The parent adds
// one more register stage for evt.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  output logic press
);

  // Flip on the edge that sees the N-th consecutive disagreeing sample,
  // i.e. when the counter already holds N-1.
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic       stable;
  logic       stable_d;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= 8'd0;
      press    <= 1'b0;
    end else if (ena) begin
      sync1 <= btn_raw;
      sync2 <= sync1;

      // Any sample that agrees with the stable level restarts the count.
      if (sync2 == stable) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end

      // Only rising transitions produce a press; releases are dropped here.
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/seg7_mode_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_mode_ctrl
// Four-button controller for a single seven-segment digit.
//   btn[0] increment digit (COUNT only)   btn[1] decrement digit (COUNT only)
//   btn[2] advance mode COUNT->SPIN->BLINK btn[3] toggle run (pause)
// SPIN walks one lit segment a..f per animation tick; BLINK toggles all
// segments on/off per tick.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   ena      enable; low freezes all state and forces evt to 0
//   btn[3:0] raw asynchronous push-buttons
//   disp     seg7_mode_ctrl_if.master: digit, seg_override, override_en,
//            dp, mode, evt (all registered)
// -----------------------------------------------------------------------------
module seg7_mode_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [3:0]         btn,
  seg7_mode_ctrl_if.master   disp
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .btn_raw (btn[i]),
      .press   (press[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority arbiter: lowest index wins, the rest are discarded.
  // ---------------------------------------------------------------------------
  logic [3:0] win;

  always_comb begin
    win = 4'b0000;
    if      (press[0]) win = 4'b0001;
    else if (press[1]) win = 4'b0010;
    else if (press[2]) win = 4'b0100;
    else if (press[3]) win = 4'b1000;
  end

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  mode_e       mode_q;
  logic [3:0]  digit_q;
  logic        run_q;
  logic [2:0]  pos_q;
  logic        phase_q;
  logic [15:0] presc_q;

  // The tick is consumed on the same edge the prescaler wraps.
  logic tick;
  assign tick = run_q && (presc_q == PRESC_MAX);

  mode_e       mode_n;
  logic [3:0]  digit_n;
  logic        run_n;
  logic [2:0]  pos_n;
  logic        phase_n;
  logic [15:0] presc_n;

  always_comb begin
    mode_n  = mode_q;
    digit_n = digit_q;
    run_n   = run_q;
    pos_n   = pos_q;
    phase_n = phase_q;

    // Prescaler advances only while running; a mode change restarts it so
    // the first frame of the new animation gets a full tick period.
    if (win[2]) begin
      presc_n = 16'd0;
    end else if (run_q) begin
      presc_n = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
    end else begin
      presc_n = presc_q;
    end

    if (win != 4'b0000) begin
      // A button event wins over a coincident tick; that tick is lost.
      if (win[0] && (mode_q == MODE_COUNT)) digit_n = digit_q + 4'd1;
      if (win[1] && (mode_q == MODE_COUNT)) digit_n = digit_q - 4'd1;
      if (win[2]) begin
        case (mode_q)
          MODE_COUNT: mode_n = MODE_SPIN;
          MODE_SPIN:  mode_n = MODE_BLINK;
          default:    mode_n = MODE_COUNT;
        endcase
        pos_n   = 3'd0;
        phase_n = 1'b1;
      end
      if (win[3]) run_n = ~run_q;
    end else if (tick) begin
      case (mode_q)
        MODE_SPIN:  pos_n   = (pos_q == SPIN_LAST) ? 3'd0 : pos_q + 3'd1;
        MODE_BLINK: phase_n = ~phase_q;
        default:    ;
      endcase
    end
  end

  // Single registered block: state plus every output, the outputs being
  // derived from the next state so they line up with it cycle for cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q            <= MODE_COUNT;
      digit_q           <= 4'd0;
      run_q             <= 1'b1;
      pos_q             <= 3'd0;
      phase_q           <= 1'b1;
      presc_q           <= 16'd0;
      disp.digit        <= 4'd0;
      disp.mode         <= MODE_COUNT;
      disp.dp           <= 1'b0;
      disp.override_en  <= 1'b0;
      disp.seg_override <= 7'h00;
      disp.evt          <= 4'b0000;
    end else if (ena) begin
      mode_q            <= mode_n;
      digit_q           <= digit_n;
      run_q             <= run_n;
      pos_q             <= pos_n;
      phase_q           <= phase_n;
      presc_q           <= presc_n;
      disp.digit        <= digit_n;
      disp.mode         <= mode_n;
      disp.dp           <= ~run_n;
      disp.override_en  <= (mode_n != MODE_COUNT);
      disp.seg_override <= seg_pattern(mode_n, pos_n, phase_n);
      disp.evt          <= win;
    end else begin
      // Frozen: everything holds except the event strobe, which is silenced.
      disp.evt <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_seg7_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_mode_ctrl
// Self-checking bench for seg7_mode_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A button driven high at the falling edge following rising edge n is first
// sampled at edge n+1, so its evt appears at edge n+1+DEB+3 = n+DEB+4.
// -----------------------------------------------------------------------------
module tb_seg7_mode_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 8;
  localparam int LAT  = DEB + 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [3:0] btn   = 4'b0000;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // {expected cycle (0 = don't check), expected evt}
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;

  seg7_mode_ctrl_if disp_if ();

  seg7_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .TICK_DIV        (TDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .btn   (btn),
    .disp  (disp_if)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every nonzero evt must match the head of the expected queue.
  always @(negedge clk) begin : evt_monitor
    if (rst_n && (disp_if.evt != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        check_eq("evt_spurious", 32'(disp_if.evt), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("evt", 32'(disp_if.evt), 32'(mon_e[3:0]));
        if (mon_e[35:4] != 32'd0) check_eq("evt_latency", 32'(cyc), mon_e[35:4]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_evt(input logic [3:0] mask, input int at_cyc);
    exp_q.push_back({32'(at_cyc), mask});
  endtask

  task automatic do_reset();
    check_eq("queue_empty_pre_reset", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    btn   = 4'b0000;
    step(2);
    check_eq("rst_digit",    32'(disp_if.digit),        32'h0);
    check_eq("rst_mode",     32'(disp_if.mode),         32'h0);
    check_eq("rst_ovr_en",   32'(disp_if.override_en),  32'h0);
    check_eq("rst_seg",      32'(disp_if.seg_override), 32'h0);
    check_eq("rst_dp",       32'(disp_if.dp),           32'h0);
    check_eq("rst_evt",      32'(disp_if.evt),          32'h0);
    rst_n = 1'b1;
    step(1);
  endtask

  // Clean press of one or more buttons, held long enough to be accepted,
  // then released and left to settle back to stable-low.
  task automatic press_btn(input logic [3:0] mask, input logic [3:0] exp_mask);
    btn = mask;
    expect_evt(exp_mask, cyc + LAT);
    step(LAT + 2);
    btn = 4'b0000;
    step(LAT + 6);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n, m, x;

  initial begin
    @(negedge clk);
    do_reset();

    // Bounce on btn[0]: alternating samples never accumulate.
    for (int i = 0; i < 8; i++) begin
      btn[0] = ~btn[0];
      step(1);
    end
    btn[0] = 1'b1;
    expect_evt(4'b0001, cyc + LAT);
    step(10);
    check_eq("bounce_digit", 32'(disp_if.digit), 32'h1);
    btn = 4'b0000;
    step(12);

    // Priority and wrap-around.
    do_reset();
    press_btn(4'b0011, 4'b0001);
    check_eq("prio_digit", 32'(disp_if.digit), 32'h1);
    press_btn(4'b0010, 4'b0010);
    check_eq("dec_digit_0", 32'(disp_if.digit), 32'h0);
    press_btn(4'b0010, 4'b0010);
    check_eq("dec_wrap_15", 32'(disp_if.digit), 32'hF);
    press_btn(4'b0001, 4'b0001);
    check_eq("inc_wrap_0", 32'(disp_if.digit), 32'h0);

    // SPIN: mode change restarts the prescaler, ticks every TDIV cycles.
    n = cyc;
    btn = 4'b0100;
    expect_evt(4'b0100, n + LAT);
    wait_to(n + LAT);
    check_eq("spin_mode",   32'(disp_if.mode),         32'h1);
    check_eq("spin_ovr_en", 32'(disp_if.override_en),  32'h1);
    check_eq("spin_pos0",   32'(disp_if.seg_override), 32'h01);
    x = n + LAT;
    wait_to(x + 2);
    btn = 4'b0000;
    wait_to(x + 7);
    check_eq("spin_pre_tick", 32'(disp_if.seg_override), 32'h01);
    wait_to(x + 8);
    check_eq("spin_pos1", 32'(disp_if.seg_override), 32'h02);
    wait_to(x + 16);
    check_eq("spin_pos2", 32'(disp_if.seg_override), 32'h04);
    wait_to(x + 47);
    check_eq("spin_pos5", 32'(disp_if.seg_override), 32'h20);
    wait_to(x + 48);
    check_eq("spin_wrap", 32'(disp_if.seg_override), 32'h01);

    // Pause: the btn[3] event lands on the same edge as the next tick,
    // so that tick is dropped and the pattern stays on segment a.
    m = cyc;
    btn = 4'b1000;
    expect_evt(4'b1000, m + LAT);
    wait_to(m + LAT);
    check_eq("pause_dp",        32'(disp_if.dp),           32'h1);
    check_eq("pause_tick_drop", 32'(disp_if.seg_override), 32'h01);
    wait_to(m + 12);
    btn = 4'b0000;
    wait_to(m + LAT + 100);
    check_eq("pause_frozen", 32'(disp_if.seg_override), 32'h01);
    check_eq("pause_dp_hold", 32'(disp_if.dp),          32'h1);
    btn = 4'b1000;
    expect_evt(4'b1000, m + 2 * LAT + 100);
    wait_to(m + 2 * LAT + 100);
    check_eq("resume_dp", 32'(disp_if.dp), 32'h0);
    x = cyc;
    wait_to(x + 4);
    btn = 4'b0000;
    wait_to(x + 7);
    check_eq("resume_pre_tick", 32'(disp_if.seg_override), 32'h01);
    wait_to(x + 8);
    check_eq("resume_tick", 32'(disp_if.seg_override), 32'h02);

    // Disable: everything holds, presses are not even sampled.
    ena = 1'b0;
    btn = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(5);
      check_eq("dis_evt", 32'(disp_if.evt),          32'h0);
      check_eq("dis_seg", 32'(disp_if.seg_override), 32'h02);
    end
    check_eq("dis_mode",  32'(disp_if.mode),  32'h1);
    check_eq("dis_dp",    32'(disp_if.dp),    32'h0);
    check_eq("dis_digit", 32'(disp_if.digit), 32'h0);
    btn = 4'b0000;
    step(2);
    ena = 1'b1;
    step(3);

    // BLINK: phase toggles per tick; btn[0] is ignored but still strobes,
    // and its event coincides with a tick that is therefore dropped.
    n = cyc;
    btn = 4'b0100;
    expect_evt(4'b0100, n + LAT);
    wait_to(n + LAT);
    x = n + LAT;
    check_eq("blink_mode", 32'(disp_if.mode),         32'h2);
    check_eq("blink_on",   32'(disp_if.seg_override), 32'h7F);
    wait_to(x + 2);
    btn = 4'b0000;
    wait_to(x + 8);
    check_eq("blink_off", 32'(disp_if.seg_override), 32'h00);
    wait_to(x + 16);
    check_eq("blink_on2", 32'(disp_if.seg_override), 32'h7F);
    btn = 4'b0001;
    expect_evt(4'b0001, x + 16 + LAT);
    wait_to(x + 24);
    check_eq("blink_tick_drop", 32'(disp_if.seg_override), 32'h7F);
    check_eq("blink_inc_ign",   32'(disp_if.digit),        32'h0);
    wait_to(x + 28);
    btn = 4'b0000;
    wait_to(x + 32);
    check_eq("blink_off2", 32'(disp_if.seg_override), 32'h00);
    btn = 4'b0100;
    expect_evt(4'b0100, x + 32 + LAT);
    wait_to(x + 40);
    check_eq("count_mode",   32'(disp_if.mode),         32'h0);
    check_eq("count_ovr_en", 32'(disp_if.override_en),  32'h0);
    check_eq("count_seg",    32'(disp_if.seg_override), 32'h00);
    wait_to(x + 44);
    btn = 4'b0000;
    step(12);

    // Reset in the middle of a SPIN animation and a pending btn[0] debounce.
    n = cyc;
    btn = 4'b0100;
    expect_evt(4'b0100, n + LAT);
    wait_to(n + LAT);
    check_eq("spin2_mode", 32'(disp_if.mode), 32'h1);
    btn = 4'b0001;
    step(3);
    do_reset();
    step(20);
    check_eq("post_rst_mode",  32'(disp_if.mode),  32'h0);
    check_eq("post_rst_digit", 32'(disp_if.digit), 32'h0);
    check_eq("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_mode_ctrl.md
SEG7_MODE_CTRL -- requirements
Module: seg7_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples needed to accept a button level change (range 2..255).
REQ-002 SHALL have parameter TICK_DIV, default 8, meaning clk cycles per animation tick (range 2..65535).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port ena  input  1  design enable; low freezes all state.
REQ-006 SHALL have port btn  input  4  raw, asynchronous, bouncing push-buttons (btn[0]..btn[3]).
REQ-007 SHALL have port digit  output  4  hex value for the downstream seg7 decoder.
REQ-008 SHALL have port seg_override  output  7  direct segment pattern {g,f,e,d,c,b,a}.
REQ-009 SHALL have port override_en  output  1  1 = display seg_override, 0 = display decoded digit.
REQ-010 SHALL have port dp  output  1  decimal point, 1 while paused.
REQ-011 SHALL have port mode  output  2  current mode: 0 COUNT, 1 SPIN, 2 BLINK.
REQ-012 SHALL have port evt  output  4  one-hot, one-cycle strobe of the accepted button event.

Function
REQ-013 SHALL pass each btn bit through a 2-flop synchronizer, then a per-button debouncer.
REQ-014 Debouncer SHALL flip its stable level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the stable level; any agreeing sample clears its counter.
REQ-015 A press event SHALL be a stable 0->1 transition; release events SHALL be ignored.
REQ-016 Latency: evt SHALL assert exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a clean high on btn.
REQ-017 Simultaneous press events SHALL be arbitrated by fixed priority (lowest index wins); losers SHALL be discarded, not queued.
REQ-018 btn[0] SHALL increment digit (15 wraps to 0) in COUNT; it SHALL be ignored in SPIN and BLINK, but evt[0] SHALL still strobe.
REQ-019 btn[1] SHALL decrement digit (0 wraps to 15) in COUNT; it SHALL be ignored in other modes, with evt[1] still strobing.
REQ-020 btn[2] SHALL advance mode COUNT->SPIN->BLINK->COUNT and clear the prescaler, spin position (0) and blink phase (on).
REQ-021 btn[3] SHALL toggle the run flag; dp SHALL equal ~run.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only while ena and run are 1, and SHALL emit a one-cycle tick on wrap.
REQ-023 In COUNT, override_en SHALL be 0 and ticks SHALL have no effect.
REQ-024 In SPIN, override_en SHALL be 1 and seg_override SHALL be one-hot on segment a..f at position 0..5; each tick SHALL advance the position, with 5 wrapping to 0.
REQ-025 In BLINK, override_en SHALL be 1, seg_override SHALL be 7'h7F when the phase is on and 7'h00 when it is off, and each tick SHALL toggle the phase.
REQ-026 A button event and a tick in the same cycle: the event SHALL take effect and the tick SHALL be dropped.
REQ-027 While ena=0, all registers (synchronizers, debouncers, prescaler, FSM) SHALL hold, and evt SHALL be 0.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On a clock edge with rst_n=0, the block SHALL set digit=0, mode=COUNT, run=1, dp=0, override_en=0, seg_override=0, evt=0, prescaler=0, spin position=0 and blink phase=on.
REQ-030 Reset SHALL clear synchronizers and debouncers to stable-low with counters at 0.
REQ-031 Reset mid-debounce or mid-animation SHALL discard pending state, and no evt SHALL follow release of reset unless a new qualifying press occurs.

Structure
REQ-032 Package seg7_ctrl_pkg SHALL hold the mode encoding, the SPIN segment pattern constants and the blink on/off patterns.
REQ-033 Sub-module btn_debounce (synchronizer plus counter plus rising-edge detect) SHALL be instantiated 4 times; the mode FSM, arbiter and prescaler SHALL remain in seg7_mode_ctrl.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-034 Reset: hold rst_n low for 2 cycles -> digit=0, mode=0, override_en=0, dp=0, evt=0.
REQ-035 Bounce: toggle btn[0] every cycle for 8 cycles, then hold it high for 10 cycles -> exactly one evt=4'b0001 and digit=1.
REQ-036 Priority and wrap: from digit=0, press btn[0] and btn[1] in the same cycle -> evt=4'b0001 only, digit=1; then press btn[1] twice -> digit=15.
REQ-037 SPIN: press btn[2] -> mode=1, seg_override=7'h01, then 7'h02 after 8 cycles, and 7'h01 again after 48 cycles total.
REQ-038 Pause and enable: press btn[3] in SPIN -> dp=1 and seg_override frozen for 100 cycles; press btn[3] again -> animation resumes; drive ena=0 -> all outputs hold and btn presses yield no evt.
